// File: rtl/uart_tx_word_packer.sv
// Packs a valid-strobe byte stream into BYTE_WIDTH-byte words and queues them in a
// small word FIFO exposed on a wreq/wgnt handshake; a flush pads out a partial word.
module uart_tx_word_packer #(
  parameter int unsigned BYTE_WIDTH = 4,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned FIFO_ASIZE = 3,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic [7:0]              i_byte,
  input  logic                    i_flush,
  output logic                    o_wreq,
  input  logic                    i_wgnt,
  output logic [BYTE_WIDTH*8-1:0] o_wdata,
  output logic                    o_overflow,
  output logic [31:0]             o_byte_count,
  output logic                    o_busy
);

  localparam int unsigned WordW = BYTE_WIDTH * 8;
  localparam int unsigned LaneW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam int unsigned Depth = 1 << FIFO_ASIZE;
  localparam int unsigned CntW  = FIFO_ASIZE + 1;

  // Bit offset of a stream lane inside the output word.
  function automatic int unsigned lane_base(input int unsigned lane);
    return BIG_ENDIAN ? lane * 8 : (BYTE_WIDTH - 1 - lane) * 8;
  endfunction

  logic [LaneW-1:0]      lane_q, lane_d;
  logic [WordW-1:0]      part_q, part_d;
  logic [WordW-1:0]      ins_word, push_word;
  logic [WordW-1:0]      mem_q [Depth];
  logic [FIFO_ASIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ASIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           byte_cnt_q, byte_cnt_d;

  logic        push, push_full, push_flush, push_ok, pop, full;
  int unsigned filled;

  // Packing: the current byte lands first, then any flush pads the lanes still empty.
  always_comb begin
    filled   = 32'(lane_q) + 32'(i_en);
    ins_word = part_q;
    if (i_en) begin
      ins_word[lane_base(32'(lane_q)) +: 8] = i_byte;
    end
    push_word = ins_word;
    for (int unsigned l = 0; l < BYTE_WIDTH; l++) begin
      if (l >= filled) begin
        push_word[lane_base(l) +: 8] = PAD_BYTE;
      end
    end
    push_full  = i_en && (32'(lane_q) == BYTE_WIDTH - 1);
    push_flush = i_flush && !push_full && (filled != 0);
    push       = push_full | push_flush;

    lane_d = lane_q;
    part_d = ins_word;
    if (i_en) begin
      lane_d = lane_q + LaneW'(1);
    end
    if (push) begin
      lane_d = '0;
      part_d = '0;
    end
  end

  // Word FIFO: a push into a full FIFO survives only if the head leaves this cycle.
  always_comb begin
    pop      = (count_q != '0) && i_wgnt;
    full     = (count_q == CntW'(Depth));
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + FIFO_ASIZE'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_ASIZE'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
    ovf_d      = ovf_q | (push & ~push_ok);
    byte_cnt_d = byte_cnt_q + 32'(i_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q     <= '0;
      part_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      byte_cnt_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      lane_q     <= lane_d;
      part_q     <= part_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      byte_cnt_q <= byte_cnt_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_word;
      end
    end
  end

  assign o_wreq       = (count_q != '0);
  assign o_wdata      = mem_q[rd_ptr_q];
  assign o_overflow   = ovf_q;
  assign o_byte_count = byte_cnt_q;
  assign o_busy       = (lane_q != '0) | o_wreq;

endmodule

// File: tb/tb_uart_tx_word_packer.sv
// Directed bench for uart_tx_word_packer: little- and big-endian instances share stimulus,
// and a reference model scoreboard predicts queued words, counters and status flags.
module tb_uart_tx_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_wgnt = 1'b0;
  logic [7:0]  i_byte = 8'h00;

  logic        wreq_le, ovf_le, busy_le;
  logic [31:0] wdata_le, cnt_le;
  logic        wreq_be, ovf_be, busy_be;
  logic [31:0] wdata_be, cnt_be;

  uart_tx_word_packer #(
    .BYTE_WIDTH(4), .BIG_ENDIAN(1'b0), .FIFO_ASIZE(3), .PAD_BYTE(8'h00)
  ) u_dut_le (
    .clk(clk), .rst(rst), .i_en(i_en), .i_byte(i_byte), .i_flush(i_flush),
    .o_wreq(wreq_le), .i_wgnt(i_wgnt), .o_wdata(wdata_le), .o_overflow(ovf_le),
    .o_byte_count(cnt_le), .o_busy(busy_le)
  );

  uart_tx_word_packer #(
    .BYTE_WIDTH(4), .BIG_ENDIAN(1'b1), .FIFO_ASIZE(3), .PAD_BYTE(8'h00)
  ) u_dut_be (
    .clk(clk), .rst(rst), .i_en(i_en), .i_byte(i_byte), .i_flush(i_flush),
    .o_wreq(wreq_be), .i_wgnt(i_wgnt), .o_wdata(wdata_be), .o_overflow(ovf_be),
    .o_byte_count(cnt_be), .o_busy(busy_be)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] q[$];
  logic [7:0]  mb[4];
  int unsigned mlane = 0;
  logic [31:0] mcnt = 0;
  logic        movf = 1'b0;
  bit          armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Compare present DUT state against the model, then advance the model by one edge.
  task automatic model_step();
    logic [31:0] w;
    bit          complete, fpush, pop, full;
    if (armed) begin
      chk("wreq", 32'(wreq_le), 32'(q.size() != 0));
      chk("wreq_be", 32'(wreq_be), 32'(q.size() != 0));
      chk("busy", 32'(busy_le), 32'((mlane != 0) || (q.size() != 0)));
      chk("byte_count", cnt_le, mcnt);
      chk("overflow", 32'(ovf_le), 32'(movf));
      chk("overflow_be", 32'(ovf_be), 32'(movf));
      if (q.size() != 0) begin
        chk("wdata", wdata_le, q[0]);
        chk("wdata_be", wdata_be, swap32(q[0]));
      end
    end
    if (rst) begin
      q.delete();
      mlane = 0;
      mcnt  = 0;
      movf  = 1'b0;
      armed = 1'b1;
      return;
    end
    pop      = (q.size() != 0) && i_wgnt;
    full     = (q.size() == 8);
    complete = i_en && (mlane == 3);
    if (i_en) begin
      mb[mlane] = i_byte;
      mlane++;
      mcnt++;
    end
    fpush = i_flush && !complete && (mlane != 0);
    if (pop) void'(q.pop_front());
    if (complete || fpush) begin
      for (int l = 0; l < 4; l++) begin
        w[(3 - l) * 8 +: 8] = (l < int'(mlane)) ? mb[l] : 8'h00;
      end
      mlane = 0;
      if (!full || pop) q.push_back(w);
      else movf = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_en   = 1'b1;
    i_byte = b;
    tick();
    i_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_wdata", wdata_le, 32'h0);
    chk("rst_wreq", 32'(wreq_le), 32'h0);

    // Basic packing with continuous grant.
    i_wgnt = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("first_word", wdata_le, 32'h11223344);
    chk("first_word_be", wdata_be, 32'h44332211);
    idle(2);
    chk("count4", cnt_le, 32'd4);

    // Flush of a partial word, a redundant flush, and a byte that completes with flush.
    send(8'hAA); send(8'hBB);
    idle(1);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    idle(1);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    idle(1);
    send(8'h01); send(8'h02); send(8'h03);
    i_flush = 1'b1; send(8'hCC); i_flush = 1'b0;
    idle(3);

    // Overflow: nine words against an eight-entry FIFO with no grant.
    i_wgnt = 1'b0;
    for (int i = 0; i < 36; i++) send(8'(i + 8'h40));
    idle(3);
    chk("ovf_sticky", 32'(ovf_le), 32'h1);
    i_wgnt = 1'b1;
    idle(10);
    chk("ovf_after_drain", 32'(ovf_le), 32'h1);

    // Full FIFO, ninth word lands on a granted cycle: no drop.
    do_reset();
    i_wgnt = 1'b0;
    for (int i = 0; i < 35; i++) send(8'(i + 8'h80));
    i_wgnt = 1'b1;
    send(8'hA3);
    i_wgnt = 1'b0;
    idle(2);
    chk("full_no_ovf", 32'(ovf_le), 32'h0);
    i_wgnt = 1'b1;
    idle(10);

    // Reset with a partial word and three queued words pending.
    i_wgnt = 1'b0;
    for (int i = 0; i < 14; i++) send(8'(i + 8'hC0));
    do_reset();
    chk("mid_rst_wreq", 32'(wreq_le), 32'h0);
    chk("mid_rst_busy", 32'(busy_le), 32'h0);
    chk("mid_rst_count", cnt_le, 32'h0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("post_rst_word", wdata_le, 32'h01020304);
    i_wgnt = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_packer.md
Name: uart_tx_word_packer

Overview:
Upstream feeder for the UART TX FIFO block. It accepts the byte stream from the SD file reader (a valid strobe with no backpressure), packs bytes into BYTE_WIDTH-byte words in stream order, and buffers completed words in a small word FIFO. It presents the words on a wreq/wgnt handshake that connects directly to the UART TX wreq/wgnt/wdata inputs. On an end-of-file flush it pads and emits any partial word.

Parameters:
BYTE_WIDTH, 4, bytes per output word; must equal the downstream UART TX BYTE_WIDTH (>=1)
BIG_ENDIAN, 0, lane order matching the downstream block; 0: first stream byte in top lane wdata[BYTE_WIDTH*8-1 -: 8]; 1: first stream byte in wdata[7:0]
FIFO_ASIZE, 3, word FIFO depth = 2^FIFO_ASIZE entries, all usable
PAD_BYTE, 8'h00, fill value for unused lanes of a flushed partial word

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
i_en  input  1  byte valid strobe, one byte per asserted cycle
i_byte  input  8  byte data, sampled when i_en=1
i_flush  input  1  end-of-stream pulse; pads and pushes the partial word
o_wreq  output  1  word available (connects to UART TX wreq)
i_wgnt  input  1  grant from UART TX; a word is consumed when o_wreq&i_wgnt
o_wdata  output  BYTE_WIDTH*8  head word of the FIFO (connects to UART TX wdata)
o_overflow  output  1  sticky: a completed word was dropped because the FIFO was full
o_byte_count  output  32  bytes accepted since reset, wraps modulo 2^32
o_busy  output  1  partial word pending or FIFO not empty

Behaviour:
- Reset (rst=1 at a clk edge): lane index=0, partial register=0, FIFO emptied, o_wreq=0, o_wdata=0, o_overflow=0, o_byte_count=0, o_busy=0. Reset mid-packing discards the partial word and all queued words with no emission.
- Packing: lane index runs from 0 to BYTE_WIDTH-1.
  - When i_en=1, i_byte goes to lane L: BIG_ENDIAN=0 uses bits [(BYTE_WIDTH-1-L)*8 +: 8]; BIG_ENDIAN=1 uses bits [L*8 +: 8].
  - The lane index then increments, and o_byte_count increments.
  - At L=BYTE_WIDTH-1 the assembled word (including the current byte) is pushed and the lane index wraps to 0.
- Flush:
  - When i_flush=1 and the lane index (after any same-cycle i_en byte) is nonzero, unfilled lanes are set to PAD_BYTE, the word is pushed, and the lane index goes to 0.
  - An i_en byte in the same cycle is included before padding.
  - If that byte completes the word, exactly one word is pushed and there is no extra padded word.
  - A flush with lane index 0 pushes nothing.
- FIFO: count register 0..2^FIFO_ASIZE, with circular read/write pointers wrapping modulo 2^FIFO_ASIZE.
  - o_wreq = (count != 0). o_wdata = storage[rd_ptr], registered storage with no combinational path from i_byte.
  - o_wdata is held stable while o_wreq=1 and i_wgnt=0.
  - Pop when o_wreq&i_wgnt. i_wgnt with o_wreq=0 is ignored.
  - A push is accepted if count<2^FIFO_ASIZE or a pop occurs in the same cycle; in that case pop and push both happen and count is unchanged.
  - Push when full without a same-cycle pop: the word is dropped, o_overflow is set to 1 and held until reset, and the lane index still wraps to 0.
- Latency: the word completed by the byte sampled at edge N is visible on o_wreq/o_wdata after edge N (usable in cycle N+1). Into an empty FIFO, the first grant can occur in cycle N+1.
- Throughput: one byte per cycle input; at most one word push and one word pop per cycle.
- BYTE_WIDTH=1: every i_en byte pushes immediately, and flush is a no-op.
- o_busy = (lane index != 0) | (count != 0).

Test Plan:
- BYTE_WIDTH=4, BIG_ENDIAN=0, i_wgnt=1: bytes 11,22,33,44 on consecutive cycles -> o_wreq=1 one cycle after byte 44, o_wdata=32'h11223344, then o_wreq=0; o_byte_count=4.
- BIG_ENDIAN=1: same bytes -> o_wdata=32'h44332211.
- Bytes AA,BB then i_flush on a later cycle, PAD_BYTE=00 -> one word 32'hAABB0000; second flush -> no word. Byte CC with i_flush in the same cycle after lane=3 -> word completes, exactly one push.
- FIFO_ASIZE=3, i_wgnt=0, feed 36 bytes -> 8 words queued, 9th word dropped, o_overflow=1 sticky. Then raise i_wgnt -> the 8 words drain in stream order with o_wdata held while ungranted.
- Full FIFO, 9th word completes in the same cycle as a grant -> no overflow, count stays 8, order preserved.
- Assert rst after 2 bytes and 3 queued words -> o_wreq=0, o_busy=0, o_byte_count=0 next cycle. Subsequent bytes 01..04 -> word 32'h01020304 with no stale data.
